call_stack: RTL
===============

Name: call_stack

Overview:
- Hardware return-address stack for the single-cycle datapath. It sits directly downstream of the PC logic.
- On CALL it captures pc+1. On RET it supplies the return address to the pc_src=2'b10 mux leg in the same cycle the pop is issued.
- It adds depth tracking, full/empty status, and sticky overflow/underflow error flags for the controller and for debug.

Parameters:
- ADDR_W, 12, width of a stored return address; matches the PC width.
- DEPTH, 8, number of entries; must be >= 2.
- CNT_W, $clog2(DEPTH+1), width of the occupancy counter.

Ports:
- clk  input  1  rising-edge clock shared with the datapath.
- rst  input  1  synchronous, active-high reset.
- push  input  1  store push_addr on this edge (CALL).
- pop  input  1  remove the top entry on this edge (RET).
- push_addr  input  ADDR_W  return address to store; the datapath drives pc+1.
- top_addr  output  ADDR_W  current top entry, combinational.
- count  output  CNT_W  number of valid entries.
- empty  output  1  count == 0.
- full  output  1  count == DEPTH.
- stack_overflow  output  1  sticky: a push was refused because the stack was full.
- stack_underflow  output  1  sticky: a pop was issued while the stack was empty.

Behaviour:
- Storage:
  - mem[0..DEPTH-1] of ADDR_W, plus pointer sp (0..DEPTH) registered; count = sp.
  - mem is not reset.
- top_addr:
  - Combinational: mem[sp-1] when sp > 0, else 0.
  - Valid before the edge, so the PC mux can load it on the same edge that pops.
- Reset (rst=1 at posedge):
  - sp=0, stack_overflow=0, stack_underflow=0. Therefore empty=1, full=0, count=0, top_addr=0.
  - rst overrides push and pop in the same cycle.
- Cycle behaviour by {push,pop}, evaluated at posedge when rst=0:
  - 00: no change.
  - 10, not full: mem[sp] <= push_addr; sp <= sp+1.
  - 10, full: no write; sp unchanged; stack_overflow <= 1.
  - 01, not empty: sp <= sp-1. The popped entry is not cleared.
  - 01, empty: sp stays 0; stack_underflow <= 1.
  - 11, not empty: replace the top (mem[sp-1] <= push_addr); sp unchanged. This is valid when full as well; no overflow.
  - 11, empty: mem[0] <= push_addr; sp <= 1; stack_underflow <= 1.
- Flags:
  - Sticky; cleared only by rst.
  - Both flags may be set simultaneously.
- Latency:
  - Push is visible on top_addr and count one cycle after the edge.
  - Pop affects top_addr after the edge; the pre-edge top_addr is the returned value.
- Arithmetic:
  - sp never wraps: it saturates at 0 and DEPTH per the rules above.
  - Index math is done in CNT_W bits, with no truncation of sp-1 when sp=0; guard with empty.
- No internal state machine beyond sp and the flags. All outputs are derived from registered state; there is no combinational path from push or pop to any output.
- Reset mid-operation: a push or pop coincident with rst is discarded entirely.

Decomposition:
- Shared package (cpu_pkg):
  - PC_W=12 (used as the ADDR_W default).
  - RET_STACK_DEPTH=8.
  - pc_src encodings: PC_INC=2'b00, PC_JUMP=2'b01, PC_RET=2'b10, PC_BRANCH=2'b11. The controller uses these to generate push and pop.
- No sub-module. The storage array and pointer logic stay in call_stack; a separate RAM wrapper is unnecessary at DEPTH=8.

Test Plan:
- Reset then idle: assert rst for 1 cycle -> count=0, empty=1, full=0, top_addr=0, both flags 0; hold for 3 idle cycles, unchanged.
- Push/pop order: push 12'h010, 12'h020, 12'h030 on consecutive cycles -> count=3, top_addr=12'h030. Then pop x3 -> top_addr before each edge reads 030, 020, 010; final count=0, empty=1, no flags.
- Overflow: push 12'h100..12'h107 (8 pushes) -> full=1, top_addr=12'h107. Then push 12'h1FF -> stack_overflow=1, count=8, top_addr still 12'h107. Then pop -> top_addr=12'h106, overflow stays 1.
- Underflow: after reset, pop -> stack_underflow=1, count=0, top_addr=0. Then push 12'h055 -> count=1, top_addr=12'h055, underflow still 1.
- Simultaneous push+pop:
  - With stack [12'h0A0, 12'h0B0]: assert both with push_addr=12'h0C0 -> count=2, top_addr=12'h0C0; a following pop exposes 12'h0A0.
  - When full: assert both -> top replaced, no overflow.
  - When empty: assert both with 12'h0D0 -> count=1, top_addr=12'h0D0, underflow=1.
- Reset mid-operation: with count=5 and overflow=1, assert rst together with push=1 -> count=0, flags 0, the push is ignored, top_addr=0.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared datapath constants: PC width, return-stack depth and pc_src mux encodings.
package cpu_pkg;

    localparam int PC_W            = 12;
    localparam int RET_STACK_DEPTH = 8;

    typedef enum logic [1:0] {
        PC_INC    = 2'b00,
        PC_JUMP   = 2'b01,
        PC_RET    = 2'b10,
        PC_BRANCH = 2'b11
    } pc_src_t;

endpackage

// File: rtl/call_stack.sv
// Hardware return-address stack: CALL pushes pc+1, RET pops.
// top_addr is combinational from registered state, so the PC mux can use it on the popping edge.
module call_stack
    import cpu_pkg::*;
#(
    parameter int ADDR_W = PC_W,
    parameter int DEPTH  = RET_STACK_DEPTH,
    parameter int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic              pop,
    input  logic [ADDR_W-1:0] push_addr,
    output logic [ADDR_W-1:0] top_addr,
    output logic [CNT_W-1:0]  count,
    output logic              empty,
    output logic              full,
    output logic              stack_overflow,
    output logic              stack_underflow
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [ADDR_W-1:0] mem [DEPTH];
    logic [CNT_W-1:0]  sp_reg;
    logic              overflow_reg;
    logic              underflow_reg;

    logic              empty_int;
    logic              full_int;
    logic [IDX_W-1:0]  top_idx;
    logic [IDX_W-1:0]  push_idx;
    logic [IDX_W-1:0]  wr_idx;
    logic              wr_en;

    assign empty_int = (sp_reg == '0);
    assign full_int  = (sp_reg == CNT_W'(DEPTH));

    // Only meaningful when not empty; consumers guard with empty_int.
    assign top_idx  = IDX_W'(sp_reg - CNT_W'(1));
    assign push_idx = IDX_W'(sp_reg);

    always_comb begin
        wr_en  = 1'b0;
        wr_idx = push_idx;
        if (!rst && push) begin
            if (pop) begin
                wr_en  = 1'b1;
                // Push+pop on a non-empty stack replaces the top; on empty it lands in slot 0.
                wr_idx = empty_int ? '0 : top_idx;
            end else if (!full_int) begin
                wr_en  = 1'b1;
                wr_idx = push_idx;
            end
        end
    end

    // Storage is deliberately not reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_idx] <= push_addr;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sp_reg        <= '0;
            overflow_reg  <= 1'b0;
            underflow_reg <= 1'b0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (full_int) overflow_reg <= 1'b1;
                    else          sp_reg       <= sp_reg + CNT_W'(1);
                end
                2'b01: begin
                    if (empty_int) underflow_reg <= 1'b1;
                    else           sp_reg        <= sp_reg - CNT_W'(1);
                end
                2'b11: begin
                    if (empty_int) begin
                        sp_reg        <= CNT_W'(1);
                        underflow_reg <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign top_addr        = empty_int ? '0 : mem[top_idx];
    assign count           = sp_reg;
    assign empty           = empty_int;
    assign full            = full_int;
    assign stack_overflow  = overflow_reg;
    assign stack_underflow = underflow_reg;

endmodule
